// File: rtl/lc3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_ctrl_pkg
// Brief    : States, opcodes, datapath select codes and per-state control word
//            decode for the LC-3 multicycle control sequencer.
// Revision : 1.0  initial release
// ============================================================================
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'd0,
        ST_FETCH0 = 5'd1,
        ST_FETCH1 = 5'd2,
        ST_FETCH2 = 5'd3,
        ST_DECODE = 5'd4,
        ST_ADD0   = 5'd5,
        ST_AND0   = 5'd6,
        ST_NOT0   = 5'd7,
        ST_BR0    = 5'd8,
        ST_JSR0   = 5'd9,
        ST_JSR1   = 5'd10,
        ST_RET0   = 5'd11,
        ST_LD0    = 5'd12,
        ST_LD1    = 5'd13,
        ST_LD2    = 5'd14,
        ST_ST0    = 5'd15,
        ST_ST1    = 5'd16,
        ST_ST2    = 5'd17,
        ST_ILL0   = 5'd18,
        ST_ERR    = 5'd19
    } state_t;

    localparam logic [3:0] c_op_br  = 4'b0000;
    localparam logic [3:0] c_op_add = 4'b0001;
    localparam logic [3:0] c_op_ld  = 4'b0010;
    localparam logic [3:0] c_op_st  = 4'b0011;
    localparam logic [3:0] c_op_jsr = 4'b0100;
    localparam logic [3:0] c_op_and = 4'b0101;
    localparam logic [3:0] c_op_not = 4'b1001;
    localparam logic [3:0] c_op_ret = 4'b1100;

    localparam logic [1:0] c_alu_pass = 2'b00;
    localparam logic [1:0] c_alu_add  = 2'b01;
    localparam logic [1:0] c_alu_and  = 2'b10;
    localparam logic [1:0] c_alu_not  = 2'b11;

    localparam logic [1:0] c_pc_inc = 2'b00;
    localparam logic [1:0] c_pc_eab = 2'b01;
    localparam logic [1:0] c_pc_bus = 2'b10;

    localparam logic       c_eab1_pc = 1'b0;
    localparam logic       c_eab1_ra = 1'b1;
    localparam logic [1:0] c_eab2_zero  = 2'b00;
    localparam logic [1:0] c_eab2_off6  = 2'b01;
    localparam logic [1:0] c_eab2_off9  = 2'b10;
    localparam logic [1:0] c_eab2_off11 = 2'b11;

    localparam logic c_mar_bus  = 1'b0;
    localparam logic c_mar_marm = 1'b1;
    localparam logic c_mdr_mem  = 1'b0;
    localparam logic c_mdr_bus  = 1'b1;

    typedef struct packed {
        logic [1:0] alu_ctrl;
        logic [1:0] sel_pc;
        logic       sel_eab1;
        logic [1:0] sel_eab2;
        logic       sel_mar;
        logic       sel_mdr;
        logic       ena_alu;
        logic       ena_pc;
        logic       ena_marm;
        logic       ena_mdr;
        logic       ld_pc;
        logic       ld_ir;
        logic       ld_mar;
        logic       ld_mdr;
        logic       reg_we;
        logic       flag_we;
        logic       mem_we;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    // Input-independent part of the control word; mem_ready and branch
    // qualification are layered on top in the sequencer.
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH0: begin c.ena_pc = 1'b1; c.ld_mar = 1'b1; c.sel_mar = c_mar_bus; end
            ST_FETCH1: begin c.ld_mdr = 1'b1; c.sel_mdr = c_mdr_mem; c.sel_pc = c_pc_inc; end
            ST_FETCH2: begin c.ena_mdr = 1'b1; c.ld_ir = 1'b1; end
            ST_ADD0, ST_AND0, ST_NOT0: begin
                c.ena_alu = 1'b1; c.reg_we = 1'b1; c.flag_we = 1'b1; c.retire = 1'b1;
                c.alu_ctrl = (s == ST_ADD0) ? c_alu_add :
                             (s == ST_AND0) ? c_alu_and : c_alu_not;
            end
            ST_BR0: begin
                c.sel_eab1 = c_eab1_pc; c.sel_eab2 = c_eab2_off9;
                c.sel_pc = c_pc_eab; c.retire = 1'b1;
            end
            ST_JSR0: begin c.ena_pc = 1'b1; c.reg_we = 1'b1; end
            ST_JSR1: begin
                c.sel_eab1 = c_eab1_pc; c.sel_eab2 = c_eab2_off11;
                c.sel_pc = c_pc_eab; c.ld_pc = 1'b1; c.retire = 1'b1;
            end
            ST_RET0: begin
                c.sel_eab1 = c_eab1_ra; c.sel_eab2 = c_eab2_zero;
                c.sel_pc = c_pc_eab; c.ld_pc = 1'b1; c.retire = 1'b1;
            end
            ST_LD0, ST_ST0: begin
                c.sel_eab1 = c_eab1_pc; c.sel_eab2 = c_eab2_off9;
                c.ena_marm = 1'b1; c.ld_mar = 1'b1; c.sel_mar = c_mar_marm;
            end
            ST_LD1:  begin c.ld_mdr = 1'b1; c.sel_mdr = c_mdr_mem; end
            ST_LD2:  begin c.ena_mdr = 1'b1; c.reg_we = 1'b1; c.flag_we = 1'b1; c.retire = 1'b1; end
            ST_ST1: begin
                c.ena_alu = 1'b1; c.alu_ctrl = c_alu_pass;
                c.ld_mdr = 1'b1; c.sel_mdr = c_mdr_bus;
            end
            ST_ST2:  c.mem_we = 1'b1;
            ST_ILL0: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : lc3_ctrl_fsm_if
// Brief    : Datapath status inputs and control outputs of the LC-3 sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface lc3_ctrl_fsm_if #(
    parameter int OPC_W = 4,
    parameter int CNT_W = 16
) ();
    logic [OPC_W-1:0] ir_opcode;
    logic [2:0]       ir_nzp;
    logic [2:0]       flag_nzp;
    logic             mem_ready;

    logic [1:0]       alu_ctrl;
    logic [1:0]       sel_pc;
    logic             sel_eab1;
    logic [1:0]       sel_eab2;
    logic             sel_mar;
    logic             sel_mdr;
    logic             ena_alu;
    logic             ena_pc;
    logic             ena_marm;
    logic             ena_mdr;
    logic             ld_pc;
    logic             ld_ir;
    logic             ld_mar;
    logic             ld_mdr;
    logic             reg_we;
    logic             flag_we;
    logic             mem_we;
    logic             retire;
    logic [CNT_W-1:0] instr_cnt;
    logic             illegal;
    logic             bus_err;

    modport master (
        input  ir_opcode, ir_nzp, flag_nzp, mem_ready,
        output alu_ctrl, sel_pc, sel_eab1, sel_eab2, sel_mar, sel_mdr,
               ena_alu, ena_pc, ena_marm, ena_mdr,
               ld_pc, ld_ir, ld_mar, ld_mdr, reg_we, flag_we, mem_we,
               retire, instr_cnt, illegal, bus_err
    );

    modport slave (
        output ir_opcode, ir_nzp, flag_nzp, mem_ready,
        input  alu_ctrl, sel_pc, sel_eab1, sel_eab2, sel_mar, sel_mdr,
               ena_alu, ena_pc, ena_marm, ena_mdr,
               ld_pc, ld_ir, ld_mar, ld_mdr, reg_we, flag_we, mem_we,
               retire, instr_cnt, illegal, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_wait_timer
// Brief    : Counts consecutive memory stall cycles within one state and flags
//            the cycle on which the stall budget is exhausted.
// Revision : 1.0  initial release
// ============================================================================
module lc3_mem_wait_timer #(
    parameter int TMO_CYC = 15
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_stall,
    output logic      o_timeout
);
    localparam logic [7:0] c_last = 8'(TMO_CYC - 1);

    logic [7:0] r_cnt;

    // Timeout fires during the TMO_CYC-th stall cycle so the FSM leaves on that edge.
    assign o_timeout = i_stall && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_stall && !o_timeout) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/lc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : lc3_ctrl_fsm
// Brief    : Multicycle LC-3 control sequencer with memory wait states, bus
//            timeout, illegal-opcode trap and retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module lc3_ctrl_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int MEM_WAIT = 1,
    parameter int TMO_CYC  = 15,
    parameter int CNT_W    = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    lc3_ctrl_fsm_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_bus_err;

    logic w_mem_ok;
    logic w_wait_state;
    logic w_stall;
    logic w_timeout;
    logic w_taken;
    logic w_retire;

    function automatic state_t op_to_state(input logic [OPC_W-1:0] op);
        state_t s;
        case (op)
            OPC_W'(c_op_add): s = ST_ADD0;
            OPC_W'(c_op_and): s = ST_AND0;
            OPC_W'(c_op_not): s = ST_NOT0;
            OPC_W'(c_op_br):  s = ST_BR0;
            OPC_W'(c_op_jsr): s = ST_JSR0;
            OPC_W'(c_op_ld):  s = ST_LD0;
            OPC_W'(c_op_st):  s = ST_ST0;
            OPC_W'(c_op_ret): s = ST_RET0;
            default:          s = ST_ILL0;
        endcase
        return s;
    endfunction

    assign w_mem_ok     = (MEM_WAIT == 0) || bus.mem_ready;
    assign w_wait_state = (r_state == ST_FETCH1) || (r_state == ST_LD1) || (r_state == ST_ST2);
    assign w_stall      = w_wait_state && !w_mem_ok;
    assign w_taken      = |(bus.ir_nzp & bus.flag_nzp);

    lc3_mem_wait_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_next != r_state),
        .i_stall   (w_stall),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH0;
            ST_FETCH0: w_next = ST_FETCH1;
            ST_FETCH1: w_next = w_timeout ? ST_ERR : (w_mem_ok ? ST_FETCH2 : ST_FETCH1);
            ST_FETCH2: w_next = ST_DECODE;
            ST_DECODE: w_next = op_to_state(bus.ir_opcode);
            ST_JSR0:   w_next = ST_JSR1;
            ST_LD0:    w_next = ST_LD1;
            ST_LD1:    w_next = w_timeout ? ST_ERR : (w_mem_ok ? ST_LD2 : ST_LD1);
            ST_ST0:    w_next = ST_ST1;
            ST_ST1:    w_next = ST_ST2;
            ST_ST2:    w_next = w_timeout ? ST_ERR : (w_mem_ok ? ST_FETCH0 : ST_ST2);
            ST_ADD0, ST_AND0, ST_NOT0, ST_BR0,
            ST_JSR1, ST_RET0, ST_LD2, ST_ILL0:
                       w_next = ST_FETCH0;
            ST_ERR:    w_next = ST_ERR;
            default:   w_next = ST_IDLE;
        endcase
    end

    // ST2 only completes once the write is accepted.
    assign w_retire = r_ctrl.retire || ((r_state == ST_ST2) && w_mem_ok);

    // Control word is registered from the next state, keeping outputs glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ctrl      <= '0;
            r_instr_cnt <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_decode(w_next);
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (w_next == ST_ERR) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus.alu_ctrl  = r_ctrl.alu_ctrl;
    assign bus.sel_pc    = r_ctrl.sel_pc;
    assign bus.sel_eab1  = r_ctrl.sel_eab1;
    assign bus.sel_eab2  = r_ctrl.sel_eab2;
    assign bus.sel_mar   = r_ctrl.sel_mar;
    assign bus.sel_mdr   = r_ctrl.sel_mdr;
    assign bus.ena_alu   = r_ctrl.ena_alu;
    assign bus.ena_pc    = r_ctrl.ena_pc;
    assign bus.ena_marm  = r_ctrl.ena_marm;
    assign bus.ena_mdr   = r_ctrl.ena_mdr;
    // PC increments once per fetch, on the cycle memory returns the word.
    assign bus.ld_pc     = r_ctrl.ld_pc
                         || ((r_state == ST_FETCH1) && w_mem_ok)
                         || ((r_state == ST_BR0) && w_taken);
    assign bus.ld_ir     = r_ctrl.ld_ir;
    assign bus.ld_mar    = r_ctrl.ld_mar;
    assign bus.ld_mdr    = r_ctrl.ld_mdr;
    assign bus.reg_we    = r_ctrl.reg_we;
    assign bus.flag_we   = r_ctrl.flag_we;
    assign bus.mem_we    = r_ctrl.mem_we;
    assign bus.retire    = w_retire;
    assign bus.instr_cnt = r_instr_cnt;
    assign bus.illegal   = r_ctrl.illegal;
    assign bus.bus_err   = r_bus_err;
endmodule
`default_nettype wire

// File: tb/tb_lc3_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_ctrl_fsm
// Brief    : Randomised instruction-level checks of lc3_ctrl_fsm.
// Revision : 1.0  initial release
// ============================================================================
module tb_lc3_ctrl_fsm;
    localparam int OPC_W = 4;
    localparam int CNT_W = 4;
    localparam int TMO   = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lc3_ctrl_fsm_if #(.OPC_W(OPC_W), .CNT_W(CNT_W)) bus_if ();

    lc3_ctrl_fsm #(
        .OPC_W(OPC_W), .MEM_WAIT(1), .TMO_CYC(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: stall budgets for the fetch read and the execute access.
    int stall_f_left, stall_e_left;
    bit in_fetch;

    int a_cycles, a_reg_we, a_flag_we, a_mem_we, a_ld_pc, a_ld_ir, a_ld_mdr;
    int a_retire, a_illegal, a_multi_ena;
    logic [1:0] a_alu;
    int exp_cnt;

    function automatic logic [31:0] all_outs();
        return {5'd0, bus_if.alu_ctrl, bus_if.sel_pc, bus_if.sel_eab1, bus_if.sel_eab2,
                bus_if.sel_mar, bus_if.sel_mdr, bus_if.ena_alu, bus_if.ena_pc,
                bus_if.ena_marm, bus_if.ena_mdr, bus_if.ld_pc, bus_if.ld_ir, bus_if.ld_mar,
                bus_if.ld_mdr, bus_if.reg_we, bus_if.flag_we, bus_if.mem_we,
                bus_if.retire, bus_if.illegal, bus_if.bus_err, bus_if.instr_cnt};
    endfunction

    function automatic logic [12:0] strobes();
        return {bus_if.ena_alu, bus_if.ena_pc, bus_if.ena_marm, bus_if.ena_mdr,
                bus_if.ld_pc, bus_if.ld_ir, bus_if.ld_mar, bus_if.ld_mdr, bus_if.reg_we,
                bus_if.flag_we, bus_if.mem_we, bus_if.retire, bus_if.illegal};
    endfunction

    task automatic clear_acc();
        a_cycles = 0; a_reg_we = 0; a_flag_we = 0; a_mem_we = 0; a_ld_pc = 0;
        a_ld_ir = 0; a_ld_mdr = 0; a_retire = 0; a_illegal = 0; a_multi_ena = 0;
        a_alu = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_if.ld_mdr && !bus_if.sel_mdr && in_fetch) begin
            if (stall_f_left > 0) begin bus_if.mem_ready = 1'b0; stall_f_left--; end
            else bus_if.mem_ready = 1'b1;
        end else if ((bus_if.ld_mdr && !bus_if.sel_mdr) || bus_if.mem_we) begin
            if (stall_e_left > 0) begin bus_if.mem_ready = 1'b0; stall_e_left--; end
            else bus_if.mem_ready = 1'b1;
        end else begin
            bus_if.mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        a_cycles++;
        a_reg_we  += int'(bus_if.reg_we);
        a_flag_we += int'(bus_if.flag_we);
        a_mem_we  += int'(bus_if.mem_we);
        a_ld_pc   += int'(bus_if.ld_pc);
        a_ld_ir   += int'(bus_if.ld_ir);
        a_ld_mdr  += int'(bus_if.ld_mdr);
        a_retire  += int'(bus_if.retire);
        a_illegal += int'(bus_if.illegal);
        if (int'(bus_if.ena_alu) + int'(bus_if.ena_pc) + int'(bus_if.ena_marm) + int'(bus_if.ena_mdr) > 1)
            a_multi_ena++;
        if (bus_if.reg_we && bus_if.ena_alu) a_alu = bus_if.alu_ctrl;
        if (bus_if.ld_ir) in_fetch = 1'b0;
    endtask

    // Runs one instruction and compares its cycle/strobe profile with the ISA rules.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] nzp, input logic [2:0] flg,
                             input int sf, input int se);
        bit found, done, legal, taken;
        int exec_len, e_reg, e_flag, e_mem, e_pc, e_mdr, e_alu;
        bus_if.ir_opcode = op;
        bus_if.ir_nzp    = nzp;
        bus_if.flag_nzp  = flg;
        stall_f_left = sf;
        stall_e_left = se;
        in_fetch = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            clear_acc();
            tick();
            if (bus_if.ena_pc && bus_if.ld_mar) found = 1'b1;
        end
        check_val("fetch_start", 32'(found), 32'd1);
        check_val("cnt_at_fetch", 32'(bus_if.instr_cnt), 32'(exp_cnt));
        done = 1'b0;
        for (int i = 0; i < 200 && found && !done; i++) begin
            tick();
            if (bus_if.retire || bus_if.illegal || bus_if.bus_err) done = 1'b1;
        end
        check_val("instr_end", 32'(done), 32'd1);

        taken = (nzp & flg) != 3'b000;
        legal = 1'b1; exec_len = 1; e_reg = 0; e_flag = 0; e_mem = 0; e_pc = 1; e_alu = 0;
        e_mdr = 1 + sf;
        case (op)
            4'b0001: begin e_reg = 1; e_flag = 1; e_alu = 1; end
            4'b0101: begin e_reg = 1; e_flag = 1; e_alu = 2; end
            4'b1001: begin e_reg = 1; e_flag = 1; e_alu = 3; end
            4'b0000: e_pc += int'(taken);
            4'b0100: begin exec_len = 2; e_reg = 1; e_pc += 1; end
            4'b1100: e_pc += 1;
            4'b0010: begin exec_len = 3 + se; e_reg = 1; e_flag = 1; e_mdr += 1 + se; end
            4'b0011: begin exec_len = 3 + se; e_mem = 1 + se; e_mdr += 1; end
            default: legal = 1'b0;
        endcase

        check_val($sformatf("cycles op%0h", op), 32'(a_cycles), 32'(4 + sf + exec_len));
        check_val($sformatf("reg_we op%0h", op), 32'(a_reg_we), 32'(e_reg));
        check_val($sformatf("flag_we op%0h", op), 32'(a_flag_we), 32'(e_flag));
        check_val($sformatf("mem_we op%0h", op), 32'(a_mem_we), 32'(e_mem));
        check_val($sformatf("ld_pc op%0h", op), 32'(a_ld_pc), 32'(e_pc));
        check_val($sformatf("ld_ir op%0h", op), 32'(a_ld_ir), 32'd1);
        check_val($sformatf("ld_mdr op%0h", op), 32'(a_ld_mdr), 32'(e_mdr));
        check_val($sformatf("retire op%0h", op), 32'(a_retire), 32'(legal ? 1 : 0));
        check_val($sformatf("illegal op%0h", op), 32'(a_illegal), 32'(legal ? 0 : 1));
        check_val("ena_onehot", 32'(a_multi_ena), 32'd0);
        if (e_alu != 0) check_val($sformatf("alu_ctrl op%0h", op), 32'(a_alu), 32'(e_alu));
        check_val("cnt_at_end", 32'(bus_if.instr_cnt), 32'(exp_cnt));
        if (legal) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    initial begin
        bit found, err, mem_we_seen;
        int stalls, bad, errlow;
        logic [3:0] op;
        logic [3:0] legal_ops [8];
        legal_ops = '{4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b0100, 4'b0010, 4'b0011, 4'b1100};

        bus_if.ir_opcode = '0;
        bus_if.ir_nzp    = '0;
        bus_if.flag_nzp  = '0;
        bus_if.mem_ready = 1'b0;
        stall_f_left = 0; stall_e_left = 0; in_fetch = 1'b0;
        exp_cnt = 0;
        clear_acc();

        reset = 1'b1;
        repeat (3) tick();
        check_val("reset_outs", all_outs(), 32'd0);
        reset = 1'b0;

        run_instr(4'b0001, 3'b000, 3'b000, 0, 0);
        run_instr(4'b0000, 3'b010, 3'b010, 0, 0);
        run_instr(4'b0000, 3'b010, 3'b100, 0, 0);
        run_instr(4'b0000, 3'b000, 3'b111, 1, 0);
        run_instr(4'b0000, 3'b111, 3'b001, 0, 0);
        run_instr(4'b0010, 3'b000, 3'b000, 0, 3);
        run_instr(4'b1111, 3'b000, 3'b000, 0, 0);
        run_instr(4'b0011, 3'b000, 3'b000, 2, 2);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 7)];
            else op = 4'($urandom_range(0, 15));
            run_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Reset while a store is between MDR load and memory write.
        bus_if.ir_opcode = 4'b0011;
        stall_f_left = 0; stall_e_left = 0; in_fetch = 1'b1;
        found = 1'b0; mem_we_seen = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus_if.mem_we) mem_we_seen = 1'b1;
            if (bus_if.ena_alu && bus_if.ld_mdr && bus_if.sel_mdr) found = 1'b1;
        end
        check_val("st1_reached", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        if (bus_if.mem_we) mem_we_seen = 1'b1;
        check_val("rst_st1_outs", all_outs(), 32'd0);
        tick();
        if (bus_if.mem_we) mem_we_seen = 1'b1;
        reset = 1'b0;
        exp_cnt = 0;
        tick();
        if (bus_if.mem_we) mem_we_seen = 1'b1;
        check_val("rst_then_fetch0", 32'({bus_if.ena_pc, bus_if.ld_mar}), 32'b11);
        check_val("rst_no_mem_we", 32'(mem_we_seen), 32'd0);

        // Fetch that never gets mem_ready.
        bus_if.ir_opcode = 4'b0001;
        stall_f_left = 1000; in_fetch = 1'b1;
        stalls = 0; err = 1'b0;
        for (int i = 0; i < 60 && !err; i++) begin
            tick();
            if (bus_if.bus_err) err = 1'b1;
            else if (bus_if.ld_mdr && !bus_if.sel_mdr && !bus_if.mem_ready) stalls++;
        end
        check_val("tmo_bus_err", 32'(err), 32'd1);
        check_val("tmo_stall_cycles", 32'(stalls), 32'(TMO));
        bad = 0; errlow = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (strobes() != 13'd0) bad++;
            if (!bus_if.bus_err) errlow++;
        end
        check_val("err_strobes_off", 32'(bad), 32'd0);
        check_val("err_sticky", 32'(errlow), 32'd0);
        reset = 1'b1;
        stall_f_left = 0;
        tick();
        check_val("err_cleared", all_outs(), 32'd0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
